// File: rtl/fade_profile_sched.sv
// Fading-channel profile scheduler.
// Steps through a small table of channel profiles. Each entry either skips,
// runs bypassed, or runs faded (optionally reseeding the fading model first).
// Every used entry gets a settle window with out_valid low before its RUN
// window.
// Optional feature macro: FADE_SCHED_LOOP_EN. When it is defined, the
// sequence repeats from entry 0 after the final entry until stop is pulsed.
module fade_profile_sched #(
  parameter int NUM_PROF      = 4,
  parameter int DWELL_W       = 32,
  parameter int RESEED_CYCLES = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        cfg_we,
  input  logic [$clog2(NUM_PROF)-1:0] cfg_addr,
  input  logic [1:0]                  cfg_mode,
  input  logic [DWELL_W-1:0]          cfg_dwell,
  input  logic [$clog2(NUM_PROF)-1:0] cfg_last,
  output logic                        fade_reset,
  output logic                        fade_bypass,
  output logic [$clog2(NUM_PROF)-1:0] prof_idx,
  output logic                        out_valid,
  output logic                        busy,
  output logic                        done,
  output logic                        cfg_err
);

  localparam int IDX_W  = $clog2(NUM_PROF);
  localparam int PH_MAX = (RESEED_CYCLES > SETTLE_CYCLES) ? RESEED_CYCLES : SETTLE_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_RESEED = 2'b01;
  localparam logic [1:0] MODE_SKIP   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RESEED,
    S_SETTLE,
    S_RUN,
    S_NEXT
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   last;
  logic [1:0]         mode;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [PH_W-1:0]    ph_cnt;
`ifdef FADE_SCHED_LOOP_EN
  logic               ran_any;
`endif

  logic [1:0]         tab_mode  [NUM_PROF];
  logic [DWELL_W-1:0] tab_dwell [NUM_PROF];

  logic [1:0]         ent_mode;
  logic [DWELL_W-1:0] ent_dwell;

  assign ent_mode  = tab_mode[idx];
  assign ent_dwell = tab_dwell[idx];
  assign prof_idx  = idx;

  // Profile table: cleared to "skip" on reset, writable only while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PROF; i++) begin
        tab_mode[i]  <= MODE_SKIP;
        tab_dwell[i] <= '0;
      end
    end else if (cfg_we && (state == S_IDLE)) begin
      tab_mode[cfg_addr]  <= cfg_mode;
      tab_dwell[cfg_addr] <= cfg_dwell;
    end
  end

  // Sequencer FSM; every output is registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      idx         <= '0;
      last        <= '0;
      ph_cnt      <= '0;
`ifdef FADE_SCHED_LOOP_EN
      ran_any     <= 1'b0;
`endif
      fade_reset  <= 1'b0;
      fade_bypass <= 1'b1;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= cfg_we && (state != S_IDLE);
      if ((state != S_IDLE) && stop) begin
        // Abort: back to idle with the channel bypassed, no done pulse.
        state       <= S_IDLE;
        idx         <= '0;
        fade_reset  <= 1'b0;
        fade_bypass <= 1'b1;
        out_valid   <= 1'b0;
        busy        <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !stop) begin
              state <= S_LOAD;
              idx   <= '0;
              last  <= cfg_last;
              busy  <= 1'b1;
`ifdef FADE_SCHED_LOOP_EN
              ran_any <= 1'b0;
`endif
            end
          end
          S_LOAD: begin
            mode      <= ent_mode;
            dwell_cnt <= ent_dwell;
            if ((ent_mode == MODE_SKIP) || (ent_dwell == '0)) begin
              state <= S_NEXT;
            end else if (ent_mode == MODE_RESEED) begin
              state       <= S_RESEED;
              fade_reset  <= 1'b1;
              fade_bypass <= 1'b0;
              ph_cnt      <= PH_W'(RESEED_CYCLES - 1);
            end else begin
              state       <= S_SETTLE;
              fade_bypass <= (ent_mode == MODE_BYPASS);
              ph_cnt      <= PH_W'(SETTLE_CYCLES - 1);
            end
          end
          S_RESEED: begin
            if (ph_cnt == '0) begin
              state       <= S_SETTLE;
              fade_reset  <= 1'b0;
              fade_bypass <= (mode == MODE_BYPASS);
              ph_cnt      <= PH_W'(SETTLE_CYCLES - 1);
            end else begin
              ph_cnt <= ph_cnt - 1'b1;
            end
          end
          S_SETTLE: begin
            if (ph_cnt == '0) begin
              state     <= S_RUN;
              out_valid <= 1'b1;
`ifdef FADE_SCHED_LOOP_EN
              ran_any   <= 1'b1;
`endif
            end else begin
              ph_cnt <= ph_cnt - 1'b1;
            end
          end
          S_RUN: begin
            // Counts down from a nonzero dwell, so the maximum value never wraps.
            if (dwell_cnt == DWELL_W'(1)) begin
              state     <= S_NEXT;
              out_valid <= 1'b0;
            end else begin
              dwell_cnt <= dwell_cnt - 1'b1;
            end
          end
          S_NEXT: begin
            if (idx == last) begin
`ifdef FADE_SCHED_LOOP_EN
              if (ran_any) begin
                state   <= S_LOAD;
                idx     <= '0;
                ran_any <= 1'b0;
              end else begin
                state       <= S_IDLE;
                idx         <= '0;
                fade_bypass <= 1'b1;
                busy        <= 1'b0;
                done        <= 1'b1;
              end
`else
              state       <= S_IDLE;
              idx         <= '0;
              fade_bypass <= 1'b1;
              busy        <= 1'b0;
              done        <= 1'b1;
`endif
            end else begin
              state <= S_LOAD;
              idx   <= idx + 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
